// File: rtl/usb_bank_load_ctrl_if.sv
// Bus bundle between the FX3 slave-FIFO loader and its environment.
//
// Groups the FX3 slave-FIFO pins, the RAM bank write port and the bank bookkeeping
// signals of usb_bank_load_ctrl.
//   master : the loader (drives FX3 strobes, RAM write port, bank status)
//   slave  : the environment (drives FX3 flag/data and bank releases)
// Optional macro BANK_CHECKSUM_EN adds burst_sum / burst_sum_vld.
interface usb_bank_load_ctrl_if #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned PTR_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
);
  // FX3 slave FIFO
  logic                 usb3_flaga;
  logic [31:0]          usb3_data;
  logic                 usb3_sloe_n;
  logic                 usb3_slrd_n;
  // RAM bank write port
  logic [NUM_BANKS-1:0] ram_wren;
  logic [ADDR_W-1:0]    ram_wraddr;
  logic [31:0]          ram_wdata;
  // Bank bookkeeping and status
  logic [NUM_BANKS-1:0] bank_release;
  logic [NUM_BANKS-1:0] bank_full;
  logic [PTR_W-1:0]     bank_ptr;
  logic                 busy;
  logic                 ovf_err;
`ifdef BANK_CHECKSUM_EN
  logic [31:0]          burst_sum;
  logic                 burst_sum_vld;

  modport master (
    input  usb3_flaga, usb3_data, bank_release,
    output usb3_sloe_n, usb3_slrd_n, ram_wren, ram_wraddr, ram_wdata,
    output bank_full, bank_ptr, busy, ovf_err, burst_sum, burst_sum_vld
  );
  modport slave (
    output usb3_flaga, usb3_data, bank_release,
    input  usb3_sloe_n, usb3_slrd_n, ram_wren, ram_wraddr, ram_wdata,
    input  bank_full, bank_ptr, busy, ovf_err, burst_sum, burst_sum_vld
  );
`else
  modport master (
    input  usb3_flaga, usb3_data, bank_release,
    output usb3_sloe_n, usb3_slrd_n, ram_wren, ram_wraddr, ram_wdata,
    output bank_full, bank_ptr, busy, ovf_err
  );
  modport slave (
    output usb3_flaga, usb3_data, bank_release,
    input  usb3_sloe_n, usb3_slrd_n, ram_wren, ram_wraddr, ram_wdata,
    input  bank_full, bank_ptr, busy, ovf_err
  );
`endif
endinterface

// File: rtl/usb_bank_load_ctrl.sv
// FX3 slave-FIFO to multi-bank RAM load sequencer.
//
// Waits for USB3_FLAGA to stay high for FLAG_DLY cycles, reads one BURST_LEN-word packet
// with the slave-FIFO strobes, realigns the data against the FX3 read latency (RD_LAT) and
// writes it into the current RAM bank. The bank is then marked full and the bank pointer
// advances round-robin; consumers free banks with bank_release pulses.
//
// Ports:
//   clk    : system (wrclock) clock
//   rst    : synchronous active-high reset
//   bus_io : usb_bank_load_ctrl_if.master (FX3 pins, RAM write port, bank status)
//
// Optional macro BANK_CHECKSUM_EN: adds burst_sum (mod 2^32 sum of the burst) and
// burst_sum_vld (one-cycle pulse in the commit cycle).
module usb_bank_load_ctrl #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned BURST_LEN = 256,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned FLAG_DLY  = 3,
  localparam int unsigned PTR_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int unsigned CNT_W    = $clog2(FLAG_DLY + 1)
) (
  input logic                 clk,
  input logic                 rst,
  usb_bank_load_ctrl_if.master bus_io
);

  typedef enum logic [2:0] {
    StIdle,
    StConfirm,
    StRead,
    StDrain,
    StCommit
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     flag_cnt_q, flag_cnt_d;
  logic [ADDR_W-1:0]    seq_cnt_q, seq_cnt_d;   // read length, then drain length
  logic                 ovf_q, ovf_d;
  logic [NUM_BANKS-1:0] bank_full_q, bank_full_d;
  logic [PTR_W-1:0]     bank_ptr_q, bank_ptr_d;
  logic [RD_LAT-1:0]    vld_q, vld_d;
  logic [ADDR_W-1:0]    wr_idx_q, wr_idx_d;
  logic [NUM_BANKS-1:0] wren_q, wren_d;
  logic [ADDR_W-1:0]    wraddr_q, wraddr_d;
  logic [31:0]          wdata_q, wdata_d;

  logic                 sloe_n, slrd_n;
  logic                 commit, read_start, tail;
  logic [NUM_BANKS-1:0] ptr_onehot;

  assign ptr_onehot = NUM_BANKS'(1) << bank_ptr_q;
  assign tail       = vld_q[RD_LAT-1];

  // Control FSM
  always_comb begin
    state_d    = state_q;
    flag_cnt_d = flag_cnt_q;
    seq_cnt_d  = seq_cnt_q;
    ovf_d      = ovf_q;
    sloe_n     = 1'b1;
    slrd_n     = 1'b1;
    commit     = 1'b0;
    read_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.usb3_flaga) begin
          state_d    = StConfirm;
          flag_cnt_d = CNT_W'(1);
        end
      end
      StConfirm: begin
        if (!bus_io.usb3_flaga) begin
          state_d    = StIdle;
          flag_cnt_d = '0;
        end else if (flag_cnt_q >= CNT_W'(FLAG_DLY - 1)) begin
          // Flag confirmed; hold here while the target bank is still occupied.
          flag_cnt_d = CNT_W'(FLAG_DLY);
          if (bank_full_q[bank_ptr_q]) begin
            ovf_d = 1'b1;
          end else begin
            state_d    = StRead;
            flag_cnt_d = '0;
            seq_cnt_d  = '0;
            read_start = 1'b1;
          end
        end else begin
          flag_cnt_d = flag_cnt_q + CNT_W'(1);
        end
      end
      StRead: begin
        sloe_n = 1'b0;
        slrd_n = 1'b0;
        if (seq_cnt_q == ADDR_W'(BURST_LEN - 1)) begin
          state_d   = StDrain;
          seq_cnt_d = '0;
        end else begin
          seq_cnt_d = seq_cnt_q + ADDR_W'(1);
        end
      end
      StDrain: begin
        sloe_n = 1'b0;
        if (seq_cnt_q == ADDR_W'(RD_LAT - 1)) begin
          state_d   = StCommit;
          seq_cnt_d = '0;
        end else begin
          seq_cnt_d = seq_cnt_q + ADDR_W'(1);
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bank bookkeeping: a commit on the same bank as a release wins.
  always_comb begin
    bank_full_d = (bank_full_q & ~bus_io.bank_release) | (commit ? ptr_onehot : '0);
    bank_ptr_d  = bank_ptr_q;
    if (commit) begin
      bank_ptr_d = (bank_ptr_q == PTR_W'(NUM_BANKS - 1)) ? '0 : bank_ptr_q + PTR_W'(1);
    end
  end

  // FX3 read-latency compensation and RAM write port
  always_comb begin
    vld_d[0] = ~slrd_n;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    wren_d   = tail ? ptr_onehot : '0;
    wraddr_d = tail ? wr_idx_q : wraddr_q;
    wdata_d  = tail ? bus_io.usb3_data : wdata_q;
    wr_idx_d = wr_idx_q;
    if (read_start) begin
      wr_idx_d = '0;
    end else if (tail) begin
      wr_idx_d = wr_idx_q + ADDR_W'(1);  // wraps at BURST_LEN
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      flag_cnt_q  <= '0;
      seq_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      bank_full_q <= '0;
      bank_ptr_q  <= '0;
      vld_q       <= '0;
      wr_idx_q    <= '0;
      wren_q      <= '0;
      wraddr_q    <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      flag_cnt_q  <= flag_cnt_d;
      seq_cnt_q   <= seq_cnt_d;
      ovf_q       <= ovf_d;
      bank_full_q <= bank_full_d;
      bank_ptr_q  <= bank_ptr_d;
      vld_q       <= vld_d;
      wr_idx_q    <= wr_idx_d;
      wren_q      <= wren_d;
      wraddr_q    <= wraddr_d;
      wdata_q     <= wdata_d;
    end
  end

`ifdef BANK_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  // The last word is accumulated on the edge entering commit, so the pulse carries the total.
  always_comb begin
    sum_d = sum_q;
    if (read_start) begin
      sum_d = '0;
    end else if (tail) begin
      sum_d = sum_q + bus_io.usb3_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign bus_io.burst_sum     = sum_q;
  assign bus_io.burst_sum_vld = commit;
`endif

  assign bus_io.usb3_sloe_n = sloe_n;
  assign bus_io.usb3_slrd_n = slrd_n;
  assign bus_io.ram_wren    = wren_q;
  assign bus_io.ram_wraddr  = wraddr_q;
  assign bus_io.ram_wdata   = wdata_q;
  assign bus_io.bank_full   = bank_full_q;
  assign bus_io.bank_ptr    = bank_ptr_q;
  assign bus_io.busy        = (state_q != StIdle);
  assign bus_io.ovf_err     = ovf_q;

endmodule

// File: doc/usb_bank_load_ctrl.md
Name: usb_bank_load_ctrl

Overview:
Sequencer between the FX3 USB3 slave FIFO and the multi-bank code/message RAM array. Detects a ready packet via USB3_FLAGA, drives the slave-FIFO read strobes for one fixed-length burst, and compensates for FX3 read latency. Writes each received word into the next free RAM bank using one-hot write enables, then marks that bank full until the downstream channel logic (clk_1023k domain consumers, already synchronised) releases it.

Parameters:
NUM_BANKS, 4, number of RAM banks; one-hot width of ram_wren.
BURST_LEN, 256, 32-bit words per USB packet and per bank; power of two.
ADDR_W, 8, RAM write address width; log2(BURST_LEN).
RD_LAT, 2, cycles from usb3_slrd_n low to valid usb3_data; range 1..4.
FLAG_DLY, 3, consecutive cycles USB3_FLAGA must be high before a burst starts.

Ports:
clk  in  1  system clock (wrclock domain)
rst  in  1  synchronous active-high reset
usb3_flaga  in  1  FX3 FIFO data-available flag
usb3_data  in  32  FX3 FIFO data bus
usb3_sloe_n  out  1  FX3 output enable, active low
usb3_slrd_n  out  1  FX3 read strobe, active low
ram_wren  out  NUM_BANKS  one-hot bank write enable
ram_wraddr  out  ADDR_W  write address within bank
ram_wdata  out  32  write data
bank_release  in  NUM_BANKS  one-cycle pulse per bank: consumer finished, bank free
bank_full  out  NUM_BANKS  bank holds unconsumed data
bank_ptr  out  log2(NUM_BANKS)  bank targeted by next/current burst
busy  out  1  high in any state except IDLE
ovf_err  out  1  sticky: flag confirmed while target bank full

Behaviour:
- Reset: state IDLE; usb3_sloe_n=1, usb3_slrd_n=1; ram_wren=0, ram_wraddr=0, ram_wdata=0; bank_full=0; bank_ptr=0; busy=0; ovf_err=0; flag counter 0; latency pipe cleared. Reset mid-burst aborts immediately; partially written bank is not marked full.
- States: IDLE, CONFIRM, READ, DRAIN, COMMIT.
- IDLE: flaga=1 -> CONFIRM, counter=1.
- CONFIRM: flaga=0 -> IDLE, counter=0. Counter reaches FLAG_DLY with flaga high: if bank_full[bank_ptr]=0 -> READ; else set ovf_err, stay in CONFIRM (holding) until the bank is released, then -> READ.
- READ: sloe_n=0 and slrd_n=0 for exactly BURST_LEN consecutive cycles; then -> DRAIN. flaga is ignored after READ entry (FX3 guarantees a whole packet).
- DRAIN: sloe_n=0, slrd_n=1 for RD_LAT cycles; then -> COMMIT.
- Latency: an RD_LAT-deep valid shift register is fed by ~slrd_n. When the tail is 1: ram_wren=one-hot(bank_ptr), ram_wdata=usb3_data, ram_wraddr=word index, registered (one cycle after the word is captured). Index starts at 0 per burst and wraps to 0 after BURST_LEN-1. Exactly BURST_LEN write pulses per burst.
- COMMIT (1 cycle): sloe_n=1; bank_full[bank_ptr] set; bank_ptr=(bank_ptr+1) mod NUM_BANKS; -> IDLE. Total cycles from READ entry to COMMIT = BURST_LEN+RD_LAT.
- Simultaneous events: release and set on the same bank in the same cycle -> set wins. A release of a bank not full is ignored. Multiple releases in one cycle are all honoured.
- bank_ptr is strictly round-robin; no skipping to other free banks.

Optional Feature:
BANK_CHECKSUM_EN: defined -> adds outputs burst_sum[31:0] and burst_sum_vld. burst_sum is the mod-2^32 sum of all words written in the burst. burst_sum_vld pulses one cycle in COMMIT with the final sum, and the accumulator clears at READ entry. Undefined -> ports absent, no adder logic.

Test Plan:
- Defaults; flaga high 3+ cycles; data=32'hAAAAAAAA -> slrd_n low 256 cycles; 256 ram_wren=4'b0001 pulses with addr 0..255; bank_full=4'b0001; bank_ptr=1.
- flaga high 2 cycles then low -> no slrd_n assertion; busy returns 0; FSM returns to IDLE.
- 4 back-to-back bursts, no releases, flaga held high -> bank_full=4'b1111. 5th confirmation holds in CONFIRM with ovf_err=1. bank_release=4'b0001 pulse -> burst 5 writes bank 0.
- Incrementing data 0..255, RD_LAT=3 -> word at ram_wraddr=n equals n; no word dropped or duplicated; DRAIN lasts 3 cycles.
- rst asserted at word 100 of a burst -> all outputs at reset values next cycle; bank_full=0; next burst writes bank 0 from addr 0.
- BANK_CHECKSUM_EN, data 1..256 -> burst_sum=32896 with burst_sum_vld pulsing once in COMMIT.
